if_id_stage: RTL
================

IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 Parameter NB_REG, default 32: width of PC+4 and instruction.
REQ-002 Parameter NB_ADDR, default 5: register-index width.
REQ-003 Parameter NB_CNT, default 16: width of the performance counters.
REQ-004 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-005 i_reset  input  1  asynchronous, active-high reset.
REQ-006 i_dunit_clk_en  input  1  debug-unit step enable; 0 freezes all state.
REQ-007 i_pcplus4  input  NB_REG  PC+4 from the IF stage.
REQ-008 i_instruction  input  NB_REG  fetched instruction from the IF stage.
REQ-009 i_flush  input  1  taken branch/jump resolved; squash the slot being latched.
REQ-010 i_idex_mem_read  input  1  the instruction in ID/EX is a load.
REQ-011 i_idex_rt  input  NB_ADDR  load destination register in ID/EX.
REQ-012 o_pcplus4  output  NB_REG  latched PC+4.
REQ-013 o_instruction  output  NB_REG  latched instruction.
REQ-014 o_valid  output  1  the latched slot holds a real instruction.
REQ-015 o_pc_write  output  1  drives IF i_PCWrite; 0 holds the PC.
REQ-016 o_bubble  output  1  zeroes ID/EX control this cycle.

Function
REQ-017 rs = o_instruction[25:21]; rt = o_instruction[20:16].
REQ-018 hazard = i_idex_mem_read & o_valid & (i_idex_rt != 0) & (i_idex_rt == rs | i_idex_rt == rt); combinational.
REQ-019 o_pc_write = ~hazard and o_bubble = hazard; both combinational, independent of i_dunit_clk_en.
REQ-020 On a clock edge with i_dunit_clk_en=0, all registers and counters hold.
REQ-021 On a clock edge with i_dunit_clk_en=1, registers update with the following priority.
- First, if i_flush: instruction := 0 (NOP), pcplus4 := 0, valid := 0.
- Else, if hazard: all registers hold (stall).
- Otherwise: load i_pcplus4 and i_instruction, valid := 1.
REQ-022 Simultaneous flush and hazard: flush wins; hazard deasserts the next cycle because valid=0.
REQ-023 Latency: IF to ID is 1 enabled cycle.
REQ-024 A load-use stall lasts exactly 1 enabled cycle, provided ID/EX receives the bubble.

Reset
REQ-025 On i_reset assertion, asynchronously: o_pcplus4=0, o_instruction=0, o_valid=0, counters=0.
- As a result, o_pc_write=1 and o_bubble=0.
REQ-026 Reset asserted mid-stall discards the held instruction.
REQ-027 First enabled edge after reset deassertion performs a normal load.

Configuration
REQ-028 Macro IF_ID_PERF_CNT_EN defined: outputs o_stall_cnt and o_flush_cnt (NB_CNT, saturating) are present.
- Counters increment on each enabled edge taking the stall or flush path.
- Each counter holds at all-ones once saturated.
REQ-029 Macro undefined: neither port nor counter exists; all other behaviour is identical.

Structure
REQ-030 The shared pipeline package holds:
- NOP encoding (32'h0);
- rs/rt field bit positions;
- NB_ADDR default.
REQ-031 Hazard logic is a separate sub-module hazard_detect (inputs: rs, rt, valid, mem_read, idex_rt; output: hazard), instantiated once.

Verification
REQ-032 Reset then one enabled edge with i_pcplus4=0x4, i_instruction=0x8C220000 -> o_pcplus4=0x4, o_instruction=0x8C220000, o_valid=1.
REQ-033 Latched 0x00430820 (rs=2, rt=3), i_idex_mem_read=1, i_idex_rt=3 -> o_pc_write=0, o_bubble=1; the next edge holds; then the hazard clears and the edge after that loads the new instruction.
REQ-034 Same as REQ-033 with i_idex_rt=0 -> no stall.
REQ-035 Hazard active and i_flush=1 on the same edge -> o_instruction=0, o_valid=0, o_pc_write=1 next cycle; flush count +1, stall count unchanged.
REQ-036 i_dunit_clk_en=0 for 5 edges with changing inputs -> outputs and counters unchanged; a reset pulse during this window clears all state immediately.
REQ-037 With IF_ID_PERF_CNT_EN and NB_CNT=4: 20 consecutive stall edges -> o_stall_cnt=15.

Source files
------------

// File: rtl/if_id_stage_pkg.sv
// Shared pipeline definitions for the IF/ID register and its hazard logic:
// NOP encoding, rs/rt field positions, default register-index width.
package if_id_stage_pkg;

  localparam logic [31:0] NOP         = 32'h0000_0000;
  localparam int unsigned RS_MSB      = 25;
  localparam int unsigned RS_LSB      = 21;
  localparam int unsigned RT_MSB      = 20;
  localparam int unsigned RT_LSB      = 16;
  localparam int unsigned NB_ADDR_DEF = 5;

  // Which path an IF/ID register update takes on a clock edge.
  typedef enum logic [1:0] {
    UPD_HOLD,
    UPD_FLUSH,
    UPD_STALL,
    UPD_LOAD
  } upd_e;

endpackage

// File: rtl/if_id_stage_if.sv
// IF/ID stage bus: IF-side fetch inputs, ID/EX hazard inputs, and the
// latched slot plus PC-write/bubble control outputs.
interface if_id_stage_if #(
  parameter int unsigned NB_REG  = 32,
  parameter int unsigned NB_ADDR = 5
) ();

  logic [NB_REG-1:0]  i_pcplus4;
  logic [NB_REG-1:0]  i_instruction;
  logic               i_flush;
  logic               i_idex_mem_read;
  logic [NB_ADDR-1:0] i_idex_rt;
  logic [NB_REG-1:0]  o_pcplus4;
  logic [NB_REG-1:0]  o_instruction;
  logic               o_valid;
  logic               o_pc_write;
  logic               o_bubble;

  modport master (
    output i_pcplus4, i_instruction, i_flush, i_idex_mem_read, i_idex_rt,
    input  o_pcplus4, o_instruction, o_valid, o_pc_write, o_bubble
  );

  modport slave (
    input  i_pcplus4, i_instruction, i_flush, i_idex_mem_read, i_idex_rt,
    output o_pcplus4, o_instruction, o_valid, o_pc_write, o_bubble
  );

endinterface

// File: rtl/if_id_stage_hazard_detect.sv
// Load-use hazard detector: flags when the load in ID/EX writes a register
// that the valid instruction in ID reads as rs or rt ($zero never hazards).
module hazard_detect
  import if_id_stage_pkg::*;
#(
  parameter int unsigned NB_ADDR = NB_ADDR_DEF
) (
  input  logic [NB_ADDR-1:0] i_rs,
  input  logic [NB_ADDR-1:0] i_rt,
  input  logic               i_valid,
  input  logic               i_mem_read,
  input  logic [NB_ADDR-1:0] i_idex_rt,
  output logic               o_hazard
);

  assign o_hazard = i_mem_read & i_valid & (i_idex_rt != '0) &
                    ((i_idex_rt == i_rs) | (i_idex_rt == i_rt));

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with flush, load-use stall and debug-step enable.
// Define IF_ID_PERF_CNT_EN to add saturating stall/flush counters.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter int unsigned NB_REG  = 32,
  parameter int unsigned NB_ADDR = NB_ADDR_DEF,
  parameter int unsigned NB_CNT  = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_dunit_clk_en,
`ifdef IF_ID_PERF_CNT_EN
  output logic [NB_CNT-1:0] o_stall_cnt,
  output logic [NB_CNT-1:0] o_flush_cnt,
`endif
  if_id_stage_if.slave      bus
);

  logic [NB_REG-1:0]  pcplus4_q, pcplus4_d;
  logic [NB_REG-1:0]  instr_q, instr_d;
  logic               valid_q, valid_d;
  logic [NB_ADDR-1:0] rs, rt;
  logic               hazard;
  upd_e               upd;

  assign rs = instr_q[RS_MSB:RS_LSB];
  assign rt = instr_q[RT_MSB:RT_LSB];

  hazard_detect #(.NB_ADDR(NB_ADDR)) u_hazard_detect (
    .i_rs       (rs),
    .i_rt       (rt),
    .i_valid    (valid_q),
    .i_mem_read (bus.i_idex_mem_read),
    .i_idex_rt  (bus.i_idex_rt),
    .o_hazard   (hazard)
  );

  // Flush beats stall: a squashed slot has valid=0, so the hazard drops next cycle.
  always_comb begin
    upd = UPD_HOLD;
    if (i_dunit_clk_en) begin
      if (bus.i_flush)  upd = UPD_FLUSH;
      else if (hazard)  upd = UPD_STALL;
      else              upd = UPD_LOAD;
    end
  end

  always_comb begin
    pcplus4_d = pcplus4_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    case (upd)
      UPD_FLUSH: begin
        pcplus4_d = '0;
        instr_d   = NB_REG'(NOP);
        valid_d   = 1'b0;
      end
      UPD_LOAD: begin
        pcplus4_d = bus.i_pcplus4;
        instr_d   = bus.i_instruction;
        valid_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pcplus4_q <= '0;
      instr_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      pcplus4_q <= pcplus4_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
    end
  end

`ifdef IF_ID_PERF_CNT_EN
  logic [NB_CNT-1:0] stall_cnt_q, stall_cnt_d;
  logic [NB_CNT-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (upd == UPD_STALL && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
    if (upd == UPD_FLUSH && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
`endif

  assign bus.o_pcplus4     = pcplus4_q;
  assign bus.o_instruction = instr_q;
  assign bus.o_valid       = valid_q;
  assign bus.o_pc_write    = ~hazard;
  assign bus.o_bubble      = hazard;

endmodule
